// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit BCD display scanner with blanking gaps and frame-synchronous updates.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_mux #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  bcd_out,
  output logic        dp_out,
  output logic [3:0]  anode,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CNT_W = 21;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      shadow;
  logic [15:0]      active;
  logic [3:0]       shadow_dp;
  logic [3:0]       active_dp;
  logic [3:0]       nibble;
  logic             lit;

  // Nibble of the digit currently selected by idx
  always_comb begin
    nibble = active[3:0];
    case (idx)
      2'd1:    nibble = active[7:4];
      2'd2:    nibble = active[11:8];
      2'd3:    nibble = active[15:12];
      default: nibble = active[3:0];
    endcase
  end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  // A digit is dark when it and every more-significant digit are zero; digit 0 always lit
  always_comb begin
    lit = 1'b1;
    case (idx)
      2'd3:    lit = |active[15:12];
      2'd2:    lit = |active[15:8];
      2'd1:    lit = |active[15:4];
      default: lit = 1'b1;
    endcase
  end
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      active     <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      anode      <= 4'b1111;
      bcd_out    <= 4'd0;
      dp_out     <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (en) begin
        case (state)
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= SHOW;
              cnt   <= '0;
              // Frame boundary: adopt the shadow value (pre-edge contents)
              if (idx == 2'd0 && pending) begin
                active    <= shadow;
                active_dp <= shadow_dp;
                pending   <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state      <= BLANK;
              cnt        <= '0;
              idx        <= idx + 2'd1;
              frame_done <= (idx == 2'd3);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= BLANK;
        endcase
      end

      // A coincident load wins over the transfer's pending clear
      if (load) begin
        shadow    <= data_in;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end

      if (en && state == SHOW && lit)
        anode <= ~(4'b0001 << idx);
      else
        anode <= 4'b1111;

      if (state == SHOW) begin
        bcd_out <= nibble;
        dp_out  <= active_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux with CLK_DIV=4, BLANK_CYC=2.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  anode;
  logic        pending;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit onehot_bad = 1'b0;

  seg_scan_mux #(.CLK_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data_in(data_in), .dp_in(dp_in),
    .bcd_out(bcd_out), .dp_out(dp_out), .anode(anode),
    .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && $countones(~anode) > 1) onehot_bad = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show(input int d);
    logic [3:0] exp_a;
    bit ok;
    exp_a = ~(4'b0001 << d);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (anode == exp_a) ok = 1'b1;
    end
    if (!ok) check("wait_show_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_fd();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (frame_done) ok = 1'b1;
    end
    if (!ok) check("frame_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  // Called right after frame_done is observed; walks the first lit cycle of each digit
  task automatic scan_frame(input logic [15:0] d, input logic [3:0] lit_mask);
    logic [3:0] exp_a;
    logic [15:0] dv;
    dv = d;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (6) tick();
      exp_a = lit_mask[k] ? ~(4'b0001 << k) : 4'b1111;
      check($sformatf("lz_anode_d%0d", k), 32'(anode), 32'(exp_a));
      if (lit_mask[k]) check($sformatf("lz_bcd_d%0d", k), 32'(bcd_out), 32'(dv[4*k +: 4]));
    end
  endtask

  logic [3:0] pat [12] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111,
                           4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
  logic [3:0] exp_bcd_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  int t1, t2;

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
    #2;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    tick(); tick();
    rst = 1'b0;

    // First frame shows zeros while 1234 waits in the shadow
    wait_show(0);
    check("f1_bcd_d0", 32'(bcd_out), 32'h0);
    do_load(16'h1234, 4'b0010);
    check("f1_pending", 32'(pending), 32'h1);
    wait_fd();
    check("f1_pending_end", 32'(pending), 32'h1);
    for (int d = 0; d < 4; d++) begin
      wait_show(d);
      check($sformatf("f2_bcd_d%0d", d), 32'(bcd_out), 32'(exp_bcd_1234[d]));
      check($sformatf("f2_dp_d%0d", d), 32'(dp_out), (d == 1) ? 32'h1 : 32'h0);
      if (d == 0) check("f2_pending_clear", 32'(pending), 32'h0);
    end

    // Frame period and pulse width
    wait_fd(); t1 = cyc;
    wait_fd(); t2 = cyc;
    check("frame_period", 32'(t2 - t1), 32'd24);
    tick();
    check("frame_done_width", 32'(frame_done), 32'h0);

    // Anode sequence from the first lit cycle of digit 0
    wait_show(0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      check($sformatf("anode_pat_%0d", i), 32'(anode), 32'(pat[i]));
    end

    // Load 1111 mid-frame, then 5678 exactly on the transfer edge
    do_load(16'h1111, 4'b0000);
    check("shadow1111_pending", 32'(pending), 32'h1);
    wait_fd();
    tick();
    do_load(16'h5678, 4'b0000);
    check("coincide_pending", 32'(pending), 32'h1);
    for (int d = 0; d < 4; d++) begin
      wait_show(d);
      check($sformatf("f_1111_d%0d", d), 32'(bcd_out), 32'h1);
    end
    wait_fd();
    wait_show(0);
    check("f_5678_d0", 32'(bcd_out), 32'h8);
    check("f_5678_pending", 32'(pending), 32'h0);
    wait_show(3);
    check("f_5678_d3", 32'(bcd_out), 32'h5);

    // Freeze during digit 2 and resume with the remaining count
    wait_fd();
    wait_show(2);
    tick();
    en = 1'b0;
    tick();
    check("en_off_anode", 32'(anode), 32'hF);
    repeat (9) tick();
    check("en_off_anode_hold", 32'(anode), 32'hF);
    check("en_off_bcd_hold", 32'(bcd_out), 32'h6);
    en = 1'b1;
    tick();
    check("resume_1", 32'(anode), 32'hB);
    tick();
    check("resume_2", 32'(anode), 32'hB);
    tick();
    check("resume_blank", 32'(anode), 32'hF);

    // Asynchronous reset during digit 1
    wait_show(1);
    #1 rst = 1'b1;
    #1;
    check("arst_anode", 32'(anode), 32'hF);
    check("arst_bcd", 32'(bcd_out), 32'h0);
    check("arst_dp", 32'(dp_out), 32'h0);
    check("arst_pending", 32'(pending), 32'h0);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_b1", 32'(anode), 32'hF);
    tick();
    check("post_rst_b2", 32'(anode), 32'hF);
    tick();
    check("post_rst_d0", 32'(anode), 32'hE);
    check("post_rst_bcd", 32'(bcd_out), 32'h0);

    // Leading-zero handling
    wait_fd();
    repeat (10) tick();
    do_load(16'h0070, 4'b0000);
    wait_fd();
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    scan_frame(16'h0070, 4'b0011);
`else
    scan_frame(16'h0070, 4'b1111);
`endif
    do_load(16'h0000, 4'b0000);
    wait_fd();
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    scan_frame(16'h0000, 4'b0001);
`else
    scan_frame(16'h0000, 4'b1111);
`endif

    check("anode_onehot", 32'(onehot_bad), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
